// File: rtl/pipe_pkg.sv
// Shared pipeline definitions for the 5-stage MIPS core.
// Holds the bit positions inside the WB/M/EX control groups, the group
// widths, the packed control bundle type and the all-zero NOP bundle.
package pipe_pkg;

  // Group widths
  localparam int WB_W = 2;
  localparam int M_W  = 3;
  localparam int EX_W = 5;

  // WB group: {RegWrite, MemToReg}
  localparam int WB_REGWRITE = 1;
  localparam int WB_MEMTOREG = 0;

  // M group: {MemWrite, MemRead, Branch}
  localparam int M_MEMWRITE = 2;
  localparam int M_MEMREAD  = 1;
  localparam int M_BRANCH   = 0;

  // EX group: {ALUSrc, ALUOp[2:0], RegDst}
  localparam int EX_ALUSRC   = 4;
  localparam int EX_ALUOP_HI = 3;
  localparam int EX_ALUOP_LO = 1;
  localparam int EX_REGDST   = 0;

  typedef struct packed {
    logic [WB_W-1:0] wb;
    logic [M_W-1:0]  m;
    logic [EX_W-1:0] ex;
  } ctrl_t;

  // All-zero control is a bubble: no write-back, no memory access, no branch.
  localparam ctrl_t CTRL_NOP = '0;

endpackage

// File: rtl/hazard_unit.sv
// Load-use hazard compare.
// Purely combinational: flags a stall when the instruction in EX is a load
// whose destination (rt) matches either source of the instruction in ID.
// Register $0 never creates a dependency.
// Ports:
//   ex_memread  MemRead of the instruction currently in EX
//   ex_rt       destination register of the load in EX
//   id_rs       rs field of the instruction in ID
//   id_rt       rt field of the instruction in ID (conservative for sw)
//   stall       load-use hazard detected
module hazard_unit #(
  parameter int RW = 5
) (
  input  logic          ex_memread,
  input  logic [RW-1:0] ex_rt,
  input  logic [RW-1:0] id_rs,
  input  logic [RW-1:0] id_rt,
  output logic          stall
);

  assign stall = ex_memread
               & (ex_rt != '0)
               & ((ex_rt == id_rs) | (ex_rt == id_rt));

endmodule

// File: rtl/id_ex_reg.sv
// ID/EX pipeline register with load-use hazard detection.
// Captures the WB/M/EX control groups and the decoded operands every cycle.
// A load-use hazard or a branch-taken flush replaces the control groups with
// a bubble; operand and field registers always load.
// Ports:
//   clk, reset                   rising-edge clock, synchronous active-high reset
//   wb_in, m_in, ex_in           control groups from the control unit
//   rd1_in, rd2_in               register-file read data
//   imm_in, pc4_in               sign-extended immediate, PC+4
//   rs_in, rt_in, rd_in          instruction register fields
//   flush                        branch taken in MEM, kill ID instruction
//   wb_out, m_out, ex_out        registered control groups
//   rd1_out..pc4_out             registered data
//   rs_out, rt_out, rd_out       registered fields
//   stall                        combinational load-use stall to PC and IF/ID
module id_ex_reg
  import pipe_pkg::*;
#(
  parameter int DW = 32,
  parameter int RW = 5
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [WB_W-1:0] wb_in,
  input  logic [M_W-1:0]  m_in,
  input  logic [EX_W-1:0] ex_in,
  input  logic [DW-1:0]   rd1_in,
  input  logic [DW-1:0]   rd2_in,
  input  logic [DW-1:0]   imm_in,
  input  logic [DW-1:0]   pc4_in,
  input  logic [RW-1:0]   rs_in,
  input  logic [RW-1:0]   rt_in,
  input  logic [RW-1:0]   rd_in,
  input  logic            flush,
  output logic [WB_W-1:0] wb_out,
  output logic [M_W-1:0]  m_out,
  output logic [EX_W-1:0] ex_out,
  output logic [DW-1:0]   rd1_out,
  output logic [DW-1:0]   rd2_out,
  output logic [DW-1:0]   imm_out,
  output logic [DW-1:0]   pc4_out,
  output logic [RW-1:0]   rs_out,
  output logic [RW-1:0]   rt_out,
  output logic [RW-1:0]   rd_out,
  output logic            stall
);

  ctrl_t ctrl_q;

  // Hazard is evaluated on the registered EX instruction against the live
  // ID fields, so it has no path through the register's own next state.
  hazard_unit #(.RW(RW)) u_hazard (
    .ex_memread (ctrl_q.m[M_MEMREAD]),
    .ex_rt      (rt_out),
    .id_rs      (rs_in),
    .id_rt      (rt_in),
    .stall      (stall)
  );

  // NOTE: non-blocking assignments so every register samples the pre-edge
  // values, including the stall derived from the current ctrl_q/rt_out.
  always_ff @(posedge clk) begin
    if (reset) begin
      ctrl_q  <= CTRL_NOP;
      rd1_out <= '0;
      rd2_out <= '0;
      imm_out <= '0;
      pc4_out <= '0;
      rs_out  <= '0;
      rt_out  <= '0;
      rd_out  <= '0;
    end else begin
      // Flush and stall both insert a bubble; the data still loads because
      // zero control makes it harmless.
      if (flush || stall) begin
        ctrl_q <= CTRL_NOP;
      end else begin
        ctrl_q <= '{wb: wb_in, m: m_in, ex: ex_in};
      end
      rd1_out <= rd1_in;
      rd2_out <= rd2_in;
      imm_out <= imm_in;
      pc4_out <= pc4_in;
      rs_out  <= rs_in;
      rt_out  <= rt_in;
      rd_out  <= rd_in;
    end
  end

  assign wb_out = ctrl_q.wb;
  assign m_out  = ctrl_q.m;
  assign ex_out = ctrl_q.ex;

endmodule

// File: tb/tb_id_ex_reg.sv
module tb_id_ex_reg;
  import pipe_pkg::*;

  localparam int DW = 32;
  localparam int RW = 5;
  localparam int VW = WB_W + M_W + EX_W + 4*DW + 3*RW;
  localparam int CW = WB_W + M_W + EX_W;
  localparam int OPW = EX_ALUOP_HI - EX_ALUOP_LO + 1;

  // Instruction control bundles {wb, m, ex}, built from the field positions.
  localparam logic [WB_W-1:0] WB_RW  = WB_W'(1) << WB_REGWRITE;
  localparam logic [WB_W-1:0] WB_LD  = (WB_W'(1) << WB_REGWRITE) | (WB_W'(1) << WB_MEMTOREG);
  localparam logic [OPW-1:0]  OP_R   = 3'b010;
  localparam logic [OPW-1:0]  OP_ADDI = 3'b011;
  localparam logic [OPW-1:0]  OP_BEQ = 3'b001;
  localparam logic [CW-1:0] I_LW   = {WB_LD, M_W'(1) << M_MEMREAD, EX_W'(1) << EX_ALUSRC};
  localparam logic [CW-1:0] I_ADD  = {WB_RW, 3'b000,
                                      (EX_W'(OP_R) << EX_ALUOP_LO) | (EX_W'(1) << EX_REGDST)};
  localparam logic [CW-1:0] I_SW   = {2'b00, M_W'(1) << M_MEMWRITE, EX_W'(1) << EX_ALUSRC};
  localparam logic [CW-1:0] I_ADDI = {WB_RW, 3'b000,
                                      (EX_W'(1) << EX_ALUSRC) | (EX_W'(OP_ADDI) << EX_ALUOP_LO)};
  localparam logic [CW-1:0] I_BEQ  = {2'b00, M_W'(1) << M_BRANCH, EX_W'(OP_BEQ) << EX_ALUOP_LO};
  localparam logic [CW-1:0] I_NOP  = '0;

  logic            clk = 1'b0;
  logic            reset;
  logic [WB_W-1:0] wb_in;
  logic [M_W-1:0]  m_in;
  logic [EX_W-1:0] ex_in;
  logic [DW-1:0]   rd1_in, rd2_in, imm_in, pc4_in;
  logic [RW-1:0]   rs_in, rt_in, rd_in;
  logic            flush;
  logic [WB_W-1:0] wb_out;
  logic [M_W-1:0]  m_out;
  logic [EX_W-1:0] ex_out;
  logic [DW-1:0]   rd1_out, rd2_out, imm_out, pc4_out;
  logic [RW-1:0]   rs_out, rt_out, rd_out;
  logic            stall;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  id_ex_reg #(.DW(DW), .RW(RW)) dut (
    .clk(clk), .reset(reset),
    .wb_in(wb_in), .m_in(m_in), .ex_in(ex_in),
    .rd1_in(rd1_in), .rd2_in(rd2_in), .imm_in(imm_in), .pc4_in(pc4_in),
    .rs_in(rs_in), .rt_in(rt_in), .rd_in(rd_in), .flush(flush),
    .wb_out(wb_out), .m_out(m_out), .ex_out(ex_out),
    .rd1_out(rd1_out), .rd2_out(rd2_out), .imm_out(imm_out), .pc4_out(pc4_out),
    .rs_out(rs_out), .rt_out(rt_out), .rd_out(rd_out), .stall(stall)
  );

  // Reference model: what EX sees, as one flat record.
  logic [CW-1:0] e_ctrl;
  logic [DW-1:0] e_rd1, e_rd2, e_imm, e_pc4;
  logic [RW-1:0] e_rs, e_rt, e_rd;

  // A load in EX blocks an ID instruction that reads its (non-zero) target.
  function automatic logic model_stall();
    logic is_load;
    is_load = (e_ctrl[EX_W + M_MEMREAD] === 1'b1);
    return is_load && (e_rt != 0) && (e_rt == rs_in || e_rt == rt_in);
  endfunction

  function automatic logic [VW-1:0] model_vec();
    return {e_ctrl, e_rd1, e_rd2, e_imm, e_pc4, e_rs, e_rt, e_rd};
  endfunction

  function automatic logic [VW-1:0] dut_vec();
    return {wb_out, m_out, ex_out, rd1_out, rd2_out, imm_out, pc4_out,
            rs_out, rt_out, rd_out};
  endfunction

  // Advance model and DUT by one edge; sample #1 after the edge.
  task automatic tick();
    logic kill;
    kill = flush || model_stall();
    if (reset) begin
      e_ctrl = '0; e_rd1 = '0; e_rd2 = '0; e_imm = '0; e_pc4 = '0;
      e_rs = '0; e_rt = '0; e_rd = '0;
    end else begin
      e_ctrl = kill ? I_NOP : {wb_in, m_in, ex_in};
      e_rd1 = rd1_in; e_rd2 = rd2_in; e_imm = imm_in; e_pc4 = pc4_in;
      e_rs = rs_in; e_rt = rt_in; e_rd = rd_in;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [CW-1:0] c, input logic [RW-1:0] rs,
                       input logic [RW-1:0] rt, input logic [RW-1:0] rd);
    {wb_in, m_in, ex_in} = c;
    rs_in = rs; rt_in = rt; rd_in = rd;
    rd1_in = $urandom; rd2_in = $urandom; imm_in = $urandom; pc4_in = $urandom;
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; flush = 1'b0;
    for (int i = 0; i < 2; i++) begin
      drive(CW'($urandom), RW'($urandom), RW'($urandom), RW'($urandom));
      flush = 1'($urandom);
      tick();
      checks++;
      if (dut_vec() !== '0 || stall !== 1'b0) begin
        errors++;
        $display("FAIL reset_clear cycle %0d: got outputs=%h stall=%b, want all 0", i, dut_vec(), stall);
      end
    end
    reset = 1'b0; flush = 1'b0;
    drive(I_ADD, 5'd1, 5'd2, 5'd3);
    tick();
    checks++;
    if ({wb_out, m_out, ex_out} !== {2'b10, 3'b000, 5'b00101}) begin
      errors++;
      $display("FAIL reset_release_rtype: got ctrl=%b, want 1000000101", {wb_out, m_out, ex_out});
    end
    checks++;
    if (dut_vec() !== model_vec()) begin
      errors++;
      $display("FAIL reset_release_data: got %h, want %h", dut_vec(), model_vec());
    end
  endtask

  task automatic test_load_use();
    drive(I_LW, 5'd4, 5'd8, 5'd0);
    tick();
    drive(I_ADD, 5'd8, 5'd3, 5'd9);
    checks++;
    if (stall !== 1'b1) begin
      errors++;
      $display("FAIL load_use_stall: got stall=%b, want 1", stall);
    end
    tick();
    checks++;
    if ({wb_out, m_out, ex_out} !== '0 || stall !== 1'b0) begin
      errors++;
      $display("FAIL load_use_bubble: got ctrl=%b stall=%b, want ctrl=0 stall=0",
               {wb_out, m_out, ex_out}, stall);
    end
    tick();  // IF/ID held: the add is presented again
    checks++;
    if (ex_out !== 5'b00101 || dut_vec() !== model_vec()) begin
      errors++;
      $display("FAIL load_use_replay: got ex=%b vec=%h, want ex=00101 vec=%h",
               ex_out, dut_vec(), model_vec());
    end
  endtask

  task automatic test_no_hazard();
    drive(I_LW, 5'd4, 5'd8, 5'd0);
    tick();
    drive(I_ADD, 5'd9, 5'd10, 5'd11);
    checks++;
    if (stall !== 1'b0) begin
      errors++;
      $display("FAIL no_hazard_stall: got stall=%b, want 0", stall);
    end
    tick();
    checks++;
    if ({wb_out, m_out, ex_out} !== I_ADD) begin
      errors++;
      $display("FAIL no_hazard_latch: got ctrl=%b, want %b", {wb_out, m_out, ex_out}, I_ADD);
    end
  endtask

  task automatic test_zero_reg();
    drive(I_LW, 5'd4, 5'd0, 5'd0);
    tick();
    drive(I_ADD, 5'd0, 5'd0, 5'd7);
    checks++;
    if (stall !== 1'b0) begin
      errors++;
      $display("FAIL zero_reg_stall: got stall=%b, want 0", stall);
    end
    tick();
    checks++;
    if ({wb_out, m_out, ex_out} !== I_ADD) begin
      errors++;
      $display("FAIL zero_reg_latch: got ctrl=%b, want %b", {wb_out, m_out, ex_out}, I_ADD);
    end
  endtask

  task automatic test_flush();
    drive(I_ADDI, 5'd1, 5'd2, 5'd0);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    checks++;
    if ({wb_out, m_out, ex_out} !== '0) begin
      errors++;
      $display("FAIL flush_bubble: got ctrl=%b, want 0", {wb_out, m_out, ex_out});
    end
    drive(I_LW, 5'd4, 5'd8, 5'd0);
    tick();
    drive(I_ADDI, 5'd8, 5'd2, 5'd0);
    flush = 1'b1;
    #1;
    checks++;
    if (stall !== 1'b1) begin
      errors++;
      $display("FAIL flush_with_stall_drive: got stall=%b, want 1", stall);
    end
    tick();
    flush = 1'b0;
    checks++;
    if ({wb_out, m_out, ex_out} !== '0 || dut_vec() !== model_vec()) begin
      errors++;
      $display("FAIL flush_with_stall: got vec=%h, want %h", dut_vec(), model_vec());
    end
  endtask

  task automatic test_passthrough();
    drive(I_SW, 5'd6, 5'd7, 5'd0);
    rd1_in = 32'h0000_0010; rd2_in = 32'hDEAD_BEEF;
    imm_in = 32'h0000_0004; pc4_in = 32'h0000_0040;
    tick();
    checks++;
    if (m_out !== 3'b100 || rd1_out !== 32'h0000_0010 || rd2_out !== 32'hDEAD_BEEF ||
        imm_out !== 32'h0000_0004 || pc4_out !== 32'h0000_0040 ||
        rs_out !== 5'd6 || rt_out !== 5'd7) begin
      errors++;
      $display("FAIL passthrough: got m=%b rd1=%h rd2=%h imm=%h pc4=%h rs=%0d rt=%0d, want m=100 rd1=00000010 rd2=deadbeef imm=00000004 pc4=00000040 rs=6 rt=7",
               m_out, rd1_out, rd2_out, imm_out, pc4_out, rs_out, rt_out);
    end
  endtask

  task automatic test_reset_mid_stall();
    drive(I_LW, 5'd4, 5'd5, 5'd0);
    tick();
    drive(I_ADD, 5'd5, 5'd1, 5'd2);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++;
    if (stall !== 1'b0 || dut_vec() !== '0) begin
      errors++;
      $display("FAIL reset_mid_stall: got stall=%b vec=%h, want 0", stall, dut_vec());
    end
  endtask

  task automatic test_random();
    logic [CW-1:0] table_c [6];
    table_c = '{I_LW, I_ADD, I_SW, I_ADDI, I_BEQ, I_NOP};
    for (int i = 0; i < 400; i++) begin
      drive(table_c[$urandom_range(0, 5)], RW'($urandom_range(0, 3)),
            RW'($urandom_range(0, 3)), RW'($urandom_range(0, 3)));
      flush = ($urandom_range(0, 7) == 0);
      reset = ($urandom_range(0, 49) == 0);
      #1;
      checks++;
      if (stall !== model_stall()) begin
        errors++;
        $display("FAIL random_stall cycle %0d: got %b, want %b", i, stall, model_stall());
      end
      tick();
      checks++;
      if (dut_vec() !== model_vec()) begin
        errors++;
        $display("FAIL random_regs cycle %0d: got %h, want %h", i, dut_vec(), model_vec());
      end
    end
    reset = 1'b0; flush = 1'b0;
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0;
    {wb_in, m_in, ex_in} = '0;
    rd1_in = '0; rd2_in = '0; imm_in = '0; pc4_in = '0;
    rs_in = '0; rt_in = '0; rd_in = '0;
    test_reset();
    test_load_use();
    test_no_hazard();
    test_zero_reg();
    test_flush();
    test_passthrough();
    test_reset_mid_stall();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
